usb_line_state_det: RTL and testbench
=====================================

Name: usb_line_state_det

Overview:
- Parametrised USB bus-state monitor that replaces the fixed SE0-only reset detector.
- Synchronises and deglitches the raw D+/D- receive pins and reports the filtered line state.
- Detects bus reset (SE0), suspend (idle J) and host resume (K) using independent, parametrised cycle thresholds.
- Sits between the pin receivers and the USB protocol engine; its outputs drive the protocol-engine reset and the power-management logic.

Parameters:
- RESET_CYCLES, 30000, consecutive filtered-SE0 cycles before bus reset is declared (625 us at 48 MHz).
- SUSPEND_CYCLES, 144000, consecutive filtered-J cycles before suspend is declared (3 ms at 48 MHz).
- FILTER_CYCLES, 4, consecutive identical synchronised samples required to update the filtered state (min 1).
- SYNC_STAGES, 2, input synchroniser depth (min 2).
- LOW_SPEED, 0, 1 swaps the J/K encoding (low-speed J is D-=1).

Ports:
- clk  input  1  system clock (48 MHz nominal)
- reset  input  1  synchronous, active-high reset
- usb_p_rx  input  1  raw D+ receive, asynchronous to clk
- usb_n_rx  input  1  raw D- receive, asynchronous to clk
- line_state  output  2  filtered state: 0=SE0, 1=J, 2=K, 3=SE1
- usb_reset  output  1  level; high while in RESET state
- reset_pulse  output  1  one-cycle strobe on entry to RESET
- suspend  output  1  level; high while in SUSPEND state
- resume_pulse  output  1  one-cycle strobe on K-driven exit from SUSPEND

Behaviour:
- Reset (synchronous, reset=1):
  - Synchroniser flops and filtered state load J, so line_state=1.
  - Filter counter and dwell timer load 0; FSM loads ACTIVE.
  - usb_reset, reset_pulse, suspend and resume_pulse are all 0.
  - Reset asserted mid-operation aborts any state immediately at the next edge.
- Raw encoding {p,n}:
  - 00=SE0, 11=SE1.
  - LOW_SPEED=0: 10=J, 01=K. LOW_SPEED=1: 01=J, 10=K.
- Filter:
  - The synchronised raw state feeds a stability counter that resets on any change.
  - When the counter reaches FILTER_CYCLES-1 with an unchanged input, line_state updates at the next edge.
  - Pin-to-line_state latency is SYNC_STAGES+FILTER_CYCLES cycles.
  - Pulses shorter than FILTER_CYCLES never reach line_state.
- Dwell timer:
  - Width is $clog2(max(RESET_CYCLES,SUSPEND_CYCLES)+1).
  - Clears to 0 in the cycle line_state changes; otherwise increments, saturating at its maximum.
- FSM ACTIVE:
  - line_state=SE0 and timer==RESET_CYCLES-1 -> RESET. usb_reset rises and reset_pulse=1 for exactly one cycle, RESET_CYCLES cycles after SE0 first appears on line_state.
  - line_state=J and timer==SUSPEND_CYCLES-1 -> SUSPEND; suspend rises at the next edge.
  - K and SE1 cause no transition.
- FSM RESET:
  - Stays while line_state=SE0.
  - Any other line_state -> ACTIVE; usb_reset falls at the next edge and the timer restarts, so idle J after reset can lead to suspend.
- FSM SUSPEND:
  - line_state=K -> ACTIVE; suspend falls and resume_pulse=1 for one cycle at the same edge.
  - line_state=SE0 for RESET_CYCLES -> RESET; suspend falls and reset_pulse fires, with no resume_pulse.
  - SE1 and short SE0 stay in SUSPEND.
- Simultaneous events:
  - State change and threshold cannot coincide, because a line_state change clears the timer that cycle.
  - Reset input has priority over everything.
- Outputs are registered; no combinational path from pins to outputs.
- Thresholds of 1 are legal: the transition fires one cycle after line_state settles.

Decomposition:
- Shared package usb_pkg:
  - line-state codes LS_SE0/LS_J/LS_K/LS_SE1
  - FSM state enum ST_ACTIVE/ST_RESET/ST_SUSPEND
- One sub-module, usb_line_filter: synchroniser plus stability filter, parameters SYNC_STAGES/FILTER_CYCLES/LOW_SPEED, outputs line_state.
- Top level holds the dwell timer and FSM.

Test Plan:
- Bench parameters: RESET_CYCLES=16, SUSPEND_CYCLES=40, FILTER_CYCLES=2, SYNC_STAGES=2, clocked with reset for 3 cycles.
- Bus reset: after reset, drive SE0 for 30 cycles -> line_state=0 at cycle 4; usb_reset rises at cycle 20 with a single reset_pulse; usb_reset falls 5 cycles after pins return to J.
- Short SE0: drive a 1-cycle SE0 glitch, then a 15-cycle SE0 -> glitch never visible on line_state; 15-cycle SE0 produces no usb_reset.
- Suspend and resume: hold J 50 cycles -> suspend rises 40 cycles after line_state=J; drive K 3 cycles -> suspend falls, one resume_pulse, state ACTIVE.
- Reset from suspend: in SUSPEND, drive SE0 20 cycles -> suspend falls and usb_reset rises together after 16 filtered cycles; resume_pulse stays 0.
- LOW_SPEED=1: {p,n}=01 held 50 cycles -> line_state=1 and suspend asserts; 10 -> line_state=2 and resume_pulse fires.
- Reset mid-operation: assert reset while usb_reset=1 -> next edge all outputs 0 and line_state=1 regardless of pins.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared line-state codes, FSM states and pin decoding for the USB bus-state monitor.
package usb_pkg;

  // Filtered line-state codes as reported on line_state
  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_state_e;

  // Bus-state FSM states
  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_RESET   = 2'd1,
    ST_SUSPEND = 2'd2
  } fsm_state_e;

  // Map raw {p,n} pins to a line state; low speed swaps the J/K encoding
  function automatic line_state_e decode_pins(input logic [1:0] pn, input logic low_speed);
    line_state_e ls;
    case (pn)
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      2'b10:   ls = low_speed ? LS_K : LS_J;
      default: ls = low_speed ? LS_J : LS_K;
    endcase
    return ls;
  endfunction

  // Raw {p,n} pattern of idle J for the selected speed
  function automatic logic [1:0] j_pins(input logic low_speed);
    return low_speed ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/usb_line_filter.sv
// Synchroniser plus stability filter for the raw D+/D- pins.
// line_state only follows the synchronised input once it has been steady
// for FILTER_CYCLES consecutive samples; ls_change flags the edge at which
// line_state will update so the dwell timer can clear in the same cycle.
module usb_line_filter
  import usb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int LOW_SPEED     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       ls_change
);

  localparam logic       LS_MODE = (LOW_SPEED != 0);
  localparam logic [1:0] J_PINS  = j_pins(LS_MODE);
  localparam int         CW      = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q [SYNC_STAGES];
  line_state_e   sample;
  line_state_e   held_q, held_d;
  line_state_e   line_state_q, line_state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchroniser stage samples the asynchronous pins
        always_ff @(posedge clk) begin
          if (reset) sync_q[gi] <= J_PINS;
          else       sync_q[gi] <= {usb_p_rx, usb_n_rx};
        end
      end else begin : g_rest
        // Later stages resolve metastability of the previous stage
        always_ff @(posedge clk) begin
          if (reset) sync_q[gi] <= J_PINS;
          else       sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // Count how long the synchronised state has held and decide when to update
  always_comb begin
    sample = decode_pins(sync_q[SYNC_STAGES-1], LS_MODE);
    held_d = sample;
    cnt_d  = '0;
    if (sample == held_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
    end
    line_state_d = line_state_q;
    if (cnt_d == CNT_MAX) begin
      line_state_d = sample;
    end
    ls_change = (line_state_d != line_state_q);
  end

  // Filter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q       <= LS_J;
      cnt_q        <= '0;
      line_state_q <= LS_J;
    end else begin
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      line_state_q <= line_state_d;
    end
  end

  assign line_state = line_state_q;

endmodule

// File: rtl/usb_line_state_det.sv
// USB bus-state monitor: filtered line state, bus reset, suspend and resume.
// A dwell timer measures how long line_state has been unchanged; the FSM
// compares it against the reset and suspend thresholds.
module usb_line_state_det
  import usb_pkg::*;
#(
  parameter int RESET_CYCLES   = 30000,
  parameter int SUSPEND_CYCLES = 144000,
  parameter int FILTER_CYCLES  = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int LOW_SPEED      = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       usb_reset,
  output logic       reset_pulse,
  output logic       suspend,
  output logic       resume_pulse
);

  localparam int MAX_CYC = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] RESET_LAST   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SUSPEND_LAST = TW'(SUSPEND_CYCLES - 1);

  logic [1:0]  filt_state;
  logic        ls_change;
  line_state_e ls_cur;

  logic [TW-1:0] timer_q, timer_d;
  fsm_state_e    state_q, state_d;
  logic          usb_reset_q, usb_reset_d;
  logic          reset_pulse_q, reset_pulse_d;
  logic          suspend_q, suspend_d;
  logic          resume_pulse_q, resume_pulse_d;

  usb_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .LOW_SPEED    (LOW_SPEED)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .usb_p_rx  (usb_p_rx),
    .usb_n_rx  (usb_n_rx),
    .line_state(filt_state),
    .ls_change (ls_change)
  );

  assign ls_cur = line_state_e'(filt_state);

  // Dwell timer: restart on every line-state change, otherwise count and saturate
  always_comb begin
    timer_d = timer_q;
    if (ls_change) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Bus-state transitions and the registered outputs they imply
  always_comb begin
    state_d        = state_q;
    reset_pulse_d  = 1'b0;
    resume_pulse_d = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (ls_cur == LS_SE0 && timer_q == RESET_LAST) begin
          state_d       = ST_RESET;
          reset_pulse_d = 1'b1;
        end else if (ls_cur == LS_J && timer_q == SUSPEND_LAST) begin
          state_d = ST_SUSPEND;
        end
      end
      ST_RESET: begin
        if (ls_cur != LS_SE0) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_SUSPEND: begin
        if (ls_cur == LS_K) begin
          state_d        = ST_ACTIVE;
          resume_pulse_d = 1'b1;
        end else if (ls_cur == LS_SE0 && timer_q == RESET_LAST) begin
          state_d       = ST_RESET;
          reset_pulse_d = 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
    usb_reset_d = (state_d == ST_RESET);
    suspend_d   = (state_d == ST_SUSPEND);
  end

  // FSM, timer and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q        <= '0;
      state_q        <= ST_ACTIVE;
      usb_reset_q    <= 1'b0;
      reset_pulse_q  <= 1'b0;
      suspend_q      <= 1'b0;
      resume_pulse_q <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      state_q        <= state_d;
      usb_reset_q    <= usb_reset_d;
      reset_pulse_q  <= reset_pulse_d;
      suspend_q      <= suspend_d;
      resume_pulse_q <= resume_pulse_d;
    end
  end

  assign line_state   = filt_state;
  assign usb_reset    = usb_reset_q;
  assign reset_pulse  = reset_pulse_q;
  assign suspend      = suspend_q;
  assign resume_pulse = resume_pulse_q;

endmodule

// File: tb/tb_usb_line_state_det.sv
// Directed bench for usb_line_state_det: full-speed and low-speed instances,
// small thresholds, cycle counts measured from the edge after pins change.
module tb_usb_line_state_det;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic p = 1'b1, n = 1'b0;
  logic lp = 1'b0, ln = 1'b1;

  logic [1:0] line_state, ls_line_state;
  logic usb_reset, reset_pulse, suspend, resume_pulse;
  logic ls_usb_reset, ls_reset_pulse, ls_suspend, ls_resume_pulse;

  int errors = 0;
  int checks = 0;

  int first_a, first_b, cnt_a, cnt_b, cnt_c;

  always #5 clk = ~clk;

  usb_line_state_det #(
    .RESET_CYCLES(16), .SUSPEND_CYCLES(40), .FILTER_CYCLES(2),
    .SYNC_STAGES(2), .LOW_SPEED(0)
  ) dut (
    .clk(clk), .reset(reset), .usb_p_rx(p), .usb_n_rx(n),
    .line_state(line_state), .usb_reset(usb_reset), .reset_pulse(reset_pulse),
    .suspend(suspend), .resume_pulse(resume_pulse)
  );

  usb_line_state_det #(
    .RESET_CYCLES(16), .SUSPEND_CYCLES(40), .FILTER_CYCLES(2),
    .SYNC_STAGES(2), .LOW_SPEED(1)
  ) dut_ls (
    .clk(clk), .reset(reset), .usb_p_rx(lp), .usb_n_rx(ln),
    .line_state(ls_line_state), .usb_reset(ls_usb_reset), .reset_pulse(ls_reset_pulse),
    .suspend(ls_suspend), .resume_pulse(ls_resume_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("check %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for 3 cycles with pins at idle J
    for (int k = 0; k < 3; k++) tick();
    check("reset_state", int'({line_state, usb_reset, reset_pulse, suspend, resume_pulse}), 16);
    check("reset_state_ls", int'({ls_line_state, ls_usb_reset, ls_reset_pulse, ls_suspend, ls_resume_pulse}), 16);
    reset = 1'b0;

    // Bus reset: SE0 for 30 cycles
    p = 0; n = 0;
    first_a = 0; first_b = 0; cnt_a = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (first_a == 0 && line_state == 2'd0) first_a = k;
      if (first_b == 0 && usb_reset) first_b = k;
      if (reset_pulse) cnt_a++;
    end
    check("se0_latency", first_a, 4);
    check("usb_reset_rise", first_b, 20);
    check("reset_pulse_count", cnt_a, 1);
    check("usb_reset_held", int'(usb_reset), 1);
    p = 1; n = 0;
    first_a = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_a == 0 && !usb_reset) first_a = k;
    end
    check("usb_reset_fall", first_a, 5);
    check("ls_j_after_reset", int'(line_state), 1);

    // One-cycle SE0 glitch must not reach line_state
    p = 0; n = 0;
    cnt_a = 0;
    tick();
    if (line_state == 2'd0) cnt_a++;
    p = 1; n = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (line_state == 2'd0) cnt_a++;
    end
    check("glitch_hidden", cnt_a, 0);

    // 15-cycle SE0 (one short of the threshold), then idle J into suspend
    p = 0; n = 0;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (line_state == 2'd0) cnt_a++;
      if (usb_reset || reset_pulse) cnt_b++;
    end
    p = 1; n = 0;
    first_a = 0; first_b = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (line_state == 2'd0) cnt_a++;
      if (usb_reset || reset_pulse) cnt_b++;
      if (first_a == 0 && line_state == 2'd1) first_a = k;
      if (first_b == 0 && suspend) first_b = k;
    end
    check("short_se0_cycles", cnt_a, 15);
    check("short_se0_no_reset", cnt_b, 0);
    check("j_latency", first_a, 4);
    check("suspend_rise", first_b, 44);

    // K for 3 cycles resumes
    p = 0; n = 1;
    first_a = 0; first_b = 0; cnt_a = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_a == 0 && !suspend) first_a = k;
      if (resume_pulse) begin
        cnt_a++;
        if (first_b == 0) first_b = k;
      end
      if (k == 3) begin
        p = 1; n = 0;
      end
    end
    check("suspend_fall", first_a, 5);
    check("resume_pulse_count", cnt_a, 1);
    check("resume_pulse_cycle", first_b, 5);
    check("active_after_resume", int'({usb_reset, suspend}), 0);

    // Idle J again until suspend (timer restarted when line_state went J)
    first_a = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (first_a == 0 && suspend) first_a = k;
    end
    check("suspend_again", first_a, 37);

    // Reset from suspend: SE0 for 20 cycles
    p = 0; n = 0;
    first_a = 0; first_b = 0; cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (first_a == 0 && !suspend) first_a = k;
      if (first_b == 0 && usb_reset) first_b = k;
      if (resume_pulse) cnt_a++;
      if (reset_pulse) cnt_b++;
    end
    check("susp_reset_suspend_fall", first_a, 20);
    check("susp_reset_usb_reset_rise", first_b, 20);
    check("susp_reset_no_resume", cnt_a, 0);
    check("susp_reset_pulse_count", cnt_b, 1);

    // Reset mid-operation while usb_reset=1 and pins still SE0
    lp = 1; ln = 0;
    reset = 1'b1;
    tick();
    check("midop_reset", int'({line_state, usb_reset, reset_pulse, suspend, resume_pulse}), 16);
    reset = 1'b0;
    p = 1; n = 0;

    // Low-speed encoding: {p,n}=10 is K
    for (int k = 1; k <= 6; k++) tick();
    check("ls_k_decode", int'(ls_line_state), 2);

    // Low-speed J (01) held 50 cycles -> suspend
    lp = 0; ln = 1;
    first_a = 0; first_b = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (first_a == 0 && ls_line_state == 2'd1) first_a = k;
      if (first_b == 0 && ls_suspend) first_b = k;
    end
    check("ls_j_latency", first_a, 4);
    check("ls_suspend_rise", first_b, 44);

    // Low-speed K (10) for 3 cycles -> resume
    lp = 1; ln = 0;
    first_a = 0; cnt_a = 0; cnt_c = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first_a == 0 && !ls_suspend) first_a = k;
      if (ls_resume_pulse) cnt_a++;
      if (ls_line_state == 2'd2) cnt_c++;
      if (k == 3) begin
        lp = 0; ln = 1;
      end
    end
    check("ls_suspend_fall", first_a, 5);
    check("ls_resume_pulse_count", cnt_a, 1);
    check("ls_k_cycles", cnt_c, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
